// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/funct codes, control encodings and stage bundles for ctrl_pipeline
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALUCTL_AND = 4'b0000;
    localparam logic [3:0] ALUCTL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTL_SUB = 4'b0110;
    localparam logic [3:0] ALUCTL_SLT = 4'b0111;
    localparam logic [3:0] ALUCTL_LUI = 4'b1000;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [1:0] regdst;
        logic       alusrc;
        logic       zeroext;
        logic [3:0] alucontrol;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic       branch;
        logic       bne;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Branch/jump resolve in ID, so later stages only carry what they still consume
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [1:0] regdst;
        logic       alusrc;
        logic       zeroext;
        logic [3:0] alucontrol;
        logic       memwrite;
        logic [1:0] resultsrc;
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [1:0] resultsrc;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational op/funct decode into a control bundle plus illegal flag
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl       = CTRL_BUBBLE;
        ctrl.valid = 1'b1;
        illegal    = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = REGDST_RD;
                case (funct)
                    FN_ADD:  ctrl.alucontrol = ALUCTL_ADD;
                    FN_SUB:  ctrl.alucontrol = ALUCTL_SUB;
                    FN_AND:  ctrl.alucontrol = ALUCTL_AND;
                    FN_OR:   ctrl.alucontrol = ALUCTL_OR;
                    FN_SLT:  ctrl.alucontrol = ALUCTL_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.resultsrc  = RES_MEM;
                ctrl.alucontrol = ALUCTL_ADD;
            end
            OP_SW: begin
                ctrl.memwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = ALUCTL_ADD;
            end
            OP_BEQ: begin
                ctrl.branch     = 1'b1;
                ctrl.alucontrol = ALUCTL_SUB;
            end
            OP_ADDI: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = ALUCTL_ADD;
            end
            OP_J: ctrl.jump = 1'b1;
            OP_ORI, OP_ANDI: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.zeroext    = 1'b1;
                ctrl.alucontrol = (op == OP_ORI) ? ALUCTL_OR : ALUCTL_AND;
                illegal         = !EXT_ISA;
            end
            OP_SLTI, OP_LUI: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = (op == OP_SLTI) ? ALUCTL_SLT : ALUCTL_LUI;
                illegal         = !EXT_ISA;
            end
            OP_BNE: begin
                ctrl.bne        = 1'b1;
                ctrl.alucontrol = ALUCTL_SUB;
                illegal         = !EXT_ISA;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.regwrite  = 1'b1;
                ctrl.regdst    = REGDST_RA;
                ctrl.resultsrc = RES_PC4;
                illegal        = !EXT_ISA;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl = CTRL_BUBBLE;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - ID decode with ID/EX, EX/MEM, MEM/WB control registers, illegal trap and retire count
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [5:0]       id_funct,
    input  logic             stall,
    input  logic             flush_ex,
    output logic             id_branch,
    output logic             id_bne,
    output logic             id_jump,
    output logic             id_illegal,
    output logic             ex_valid,
    output logic             ex_alusrc,
    output logic             ex_zeroext,
    output logic [1:0]       ex_regdst,
    output logic [3:0]       ex_alucontrol,
    output logic             mem_valid,
    output logic             mem_memwrite,
    output logic             wb_valid,
    output logic             wb_regwrite,
    output logic [1:0]       wb_resultsrc,
    output logic             exc_illegal,
    output logic [5:0]       exc_op,
    output logic [CNT_W-1:0] retired
);

    ctrl_t     dec;
    logic      dec_illegal;
    logic      id_live;
    logic      accept;
    ex_ctrl_t  ex_d;
    ex_ctrl_t  ex_q;
    mem_ctrl_t mem_q;
    wb_ctrl_t  wb_q;

    ctrl_decode #(.EXT_ISA(EXT_ISA)) u_decode (
        .op      (id_op),
        .funct   (id_funct),
        .ctrl    (dec),
        .illegal (dec_illegal)
    );

    assign id_live    = id_valid & dec.valid;
    assign id_illegal = id_valid & dec_illegal;
    assign id_branch  = id_live & dec.branch;
    assign id_bne     = id_live & dec.bne;
    assign id_jump    = id_live & dec.jump;
    assign accept     = id_live & ~stall & ~flush_ex;

    always_comb begin
        ex_d = '0;
        if (accept) begin
            ex_d.valid      = 1'b1;
            ex_d.regwrite   = dec.regwrite;
            ex_d.regdst     = dec.regdst;
            ex_d.alusrc     = dec.alusrc;
            ex_d.zeroext    = dec.zeroext;
            ex_d.alucontrol = dec.alucontrol;
            ex_d.memwrite   = dec.memwrite;
            ex_d.resultsrc  = dec.resultsrc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            exc_illegal <= 1'b0;
            exc_op      <= '0;
            retired     <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{valid: ex_q.valid, regwrite: ex_q.regwrite,
                       memwrite: ex_q.memwrite, resultsrc: ex_q.resultsrc};
            wb_q  <= '{valid: mem_q.valid, regwrite: mem_q.regwrite,
                       resultsrc: mem_q.resultsrc};
            // Only an illegal op that would actually have entered EX is trapped
            if (id_illegal && !stall && !flush_ex) begin
                exc_illegal <= 1'b1;
                if (!exc_illegal) begin
                    exc_op <= id_op;
                end
            end
            if (wb_q.valid) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alusrc     = ex_q.alusrc;
    assign ex_zeroext    = ex_q.zeroext;
    assign ex_regdst     = ex_q.regdst;
    assign ex_alucontrol = ex_q.alucontrol;
    assign mem_valid     = mem_q.valid;
    assign mem_memwrite  = mem_q.memwrite;
    assign wb_valid      = wb_q.valid;
    assign wb_regwrite   = wb_q.regwrite;
    assign wb_resultsrc  = wb_q.resultsrc;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - randomized and directed checks of ctrl_pipeline against a history-based model
module tb_ctrl_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, stall, flush_ex;
    logic [5:0] id_op, id_funct;

    logic [1:0]      id_branch, id_bne, id_jump, id_illegal;
    logic [1:0]      ex_valid, ex_alusrc, ex_zeroext, mem_valid, mem_memwrite;
    logic [1:0]      wb_valid, wb_regwrite, exc_illegal;
    logic [1:0][1:0] ex_regdst, wb_resultsrc;
    logic [1:0][3:0] ex_alucontrol, retired;
    logic [1:0][5:0] exc_op;

    ctrl_pipeline #(.EXT_ISA(1'b1), .CNT_W(4)) u_dut_ext (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
        .stall(stall), .flush_ex(flush_ex),
        .id_branch(id_branch[0]), .id_bne(id_bne[0]), .id_jump(id_jump[0]), .id_illegal(id_illegal[0]),
        .ex_valid(ex_valid[0]), .ex_alusrc(ex_alusrc[0]), .ex_zeroext(ex_zeroext[0]),
        .ex_regdst(ex_regdst[0]), .ex_alucontrol(ex_alucontrol[0]),
        .mem_valid(mem_valid[0]), .mem_memwrite(mem_memwrite[0]),
        .wb_valid(wb_valid[0]), .wb_regwrite(wb_regwrite[0]), .wb_resultsrc(wb_resultsrc[0]),
        .exc_illegal(exc_illegal[0]), .exc_op(exc_op[0]), .retired(retired[0])
    );

    ctrl_pipeline #(.EXT_ISA(1'b0), .CNT_W(4)) u_dut_base (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
        .stall(stall), .flush_ex(flush_ex),
        .id_branch(id_branch[1]), .id_bne(id_bne[1]), .id_jump(id_jump[1]), .id_illegal(id_illegal[1]),
        .ex_valid(ex_valid[1]), .ex_alusrc(ex_alusrc[1]), .ex_zeroext(ex_zeroext[1]),
        .ex_regdst(ex_regdst[1]), .ex_alucontrol(ex_alucontrol[1]),
        .mem_valid(mem_valid[1]), .mem_memwrite(mem_memwrite[1]),
        .wb_valid(wb_valid[1]), .wb_regwrite(wb_regwrite[1]), .wb_resultsrc(wb_resultsrc[1]),
        .exc_illegal(exc_illegal[1]), .exc_op(exc_op[1]), .retired(retired[1])
    );

    typedef struct {
        bit       ok;
        bit       rw;
        bit [1:0] rd;
        bit       as;
        bit       ze;
        bit [3:0] alu;
        bit       mw;
        bit [1:0] rs;
        bit       br;
        bit       bn;
        bit       jp;
    } dec_t;

    // acc[i][c] is what instance i accepted into EX at edge c; stage k after edge c is acc[i][c-k]
    dec_t     acc[2][0:4095];
    int       cyc = 0;
    int       last_rst = 0;
    bit       mexc[2];
    bit [5:0] mop[2];
    int       mret[2];
    int       n_chk = 0;
    int       n_fail = 0;

    function automatic dec_t zero_dec();
        dec_t z;
        z = '{ok: 0, rw: 0, rd: 0, as: 0, ze: 0, alu: 0, mw: 0, rs: 0, br: 0, bn: 0, jp: 0};
        return z;
    endfunction

    function automatic dec_t model_dec(input bit [5:0] op, input bit [5:0] fn, input bit ext);
        dec_t d;
        d = zero_dec();
        d.ok = 1;
        case (op)
            6'b000000: begin
                d.rw = 1; d.rd = 2'b01;
                case (fn)
                    6'b100000: d.alu = 4'b0010;
                    6'b100010: d.alu = 4'b0110;
                    6'b100100: d.alu = 4'b0000;
                    6'b100101: d.alu = 4'b0001;
                    6'b101010: d.alu = 4'b0111;
                    default:   d.ok = 0;
                endcase
            end
            6'b100011: begin d.rw = 1; d.as = 1; d.rs = 2'b01; d.alu = 4'b0010; end
            6'b101011: begin d.mw = 1; d.as = 1; d.alu = 4'b0010; end
            6'b000100: begin d.br = 1; d.alu = 4'b0110; end
            6'b001000: begin d.rw = 1; d.as = 1; d.alu = 4'b0010; end
            6'b000010: d.jp = 1;
            6'b001101: begin d.ok = ext; d.rw = 1; d.as = 1; d.ze = 1; d.alu = 4'b0001; end
            6'b001100: begin d.ok = ext; d.rw = 1; d.as = 1; d.ze = 1; d.alu = 4'b0000; end
            6'b001010: begin d.ok = ext; d.rw = 1; d.as = 1; d.alu = 4'b0111; end
            6'b001111: begin d.ok = ext; d.rw = 1; d.as = 1; d.alu = 4'b1000; end
            6'b000101: begin d.ok = ext; d.bn = 1; d.alu = 4'b0110; end
            6'b000011: begin d.ok = ext; d.jp = 1; d.rw = 1; d.rd = 2'b10; d.rs = 2'b10; end
            default:   d.ok = 0;
        endcase
        if (!d.ok) d = zero_dec();
        return d;
    endfunction

    function automatic dec_t stg(input int i, input int k);
        int j;
        j = cyc - k;
        if (j < 1 || j < last_rst) return zero_dec();
        return acc[i][j];
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit [5:0] op, input bit [5:0] fn,
                         input bit st, input bit fl);
        dec_t d;
        reset = r; id_valid = v; id_op = op; id_funct = fn; stall = st; flush_ex = fl;
        #1;
        for (int i = 0; i < 2; i++) begin
            d = model_dec(op, fn, i == 0);
            chk("id_branch",  i, 32'(id_branch[i]),  32'(v & d.br));
            chk("id_bne",     i, 32'(id_bne[i]),     32'(v & d.bn));
            chk("id_jump",    i, 32'(id_jump[i]),    32'(v & d.jp));
            chk("id_illegal", i, 32'(id_illegal[i]), 32'(v & !d.ok));
        end
    endtask

    task automatic tick();
        dec_t d, e, m, w;
        bit   wbv[2];
        @(posedge clk);
        for (int i = 0; i < 2; i++) wbv[i] = stg(i, 2).ok;
        if (cyc >= 4094) begin
            $display("FAIL history_overflow[0] at cycle %0d: got %0d, expected below 4094", cyc, cyc);
            $fatal(1);
        end
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                acc[i][cyc] = zero_dec();
                mexc[i] = 0; mop[i] = 0; mret[i] = 0;
            end else begin
                d = model_dec(id_op, id_funct, i == 0);
                acc[i][cyc] = (id_valid && d.ok && !stall && !flush_ex) ? d : zero_dec();
                if (id_valid && !d.ok && !stall && !flush_ex) begin
                    if (!mexc[i]) mop[i] = id_op;
                    mexc[i] = 1;
                end
                if (wbv[i]) mret[i] = (mret[i] + 1) % 16;
            end
        end
        if (reset) last_rst = cyc;
        #1;
        for (int i = 0; i < 2; i++) begin
            e = stg(i, 0); m = stg(i, 1); w = stg(i, 2);
            chk("ex_valid",      i, 32'(ex_valid[i]),      32'(e.ok));
            chk("ex_alusrc",     i, 32'(ex_alusrc[i]),     32'(e.as));
            chk("ex_zeroext",    i, 32'(ex_zeroext[i]),    32'(e.ze));
            chk("ex_regdst",     i, 32'(ex_regdst[i]),     32'(e.rd));
            chk("ex_alucontrol", i, 32'(ex_alucontrol[i]), 32'(e.alu));
            chk("mem_valid",     i, 32'(mem_valid[i]),     32'(m.ok));
            chk("mem_memwrite",  i, 32'(mem_memwrite[i]),  32'(m.mw));
            chk("wb_valid",      i, 32'(wb_valid[i]),      32'(w.ok));
            chk("wb_regwrite",   i, 32'(wb_regwrite[i]),   32'(w.rw));
            chk("wb_resultsrc",  i, 32'(wb_resultsrc[i]),  32'(w.rs));
            chk("exc_illegal",   i, 32'(exc_illegal[i]),   32'(mexc[i]));
            chk("exc_op",        i, 32'(exc_op[i]),        32'(mop[i]));
            chk("retired",       i, 32'(retired[i]),       32'(mret[i]));
        end
    endtask

    task automatic step(input bit r, input bit v, input bit [5:0] op, input bit [5:0] fn,
                        input bit st, input bit fl);
        drive(r, v, op, fn, st, fl);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 6'd0, 6'd0, 0, 0);
    endtask

    bit [5:0] ops[14] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010,
                          6'b001101, 6'b001100, 6'b001010, 6'b001111, 6'b000101, 6'b000011,
                          6'b111111, 6'b010000};
    bit [5:0] fns[7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111, 6'b000000};

    initial begin
        step(1, 0, 6'd0, 6'd0, 0, 0);
        chk("lit_reset_ex_valid", 0, 32'(ex_valid[0]), 32'd0);
        chk("lit_reset_retired",  0, 32'(retired[0]),  32'd0);

        // lw latency
        step(0, 1, 6'b100011, 6'd0, 0, 0);
        chk("lit_lw_ex_valid",  0, 32'(ex_valid[0]),      32'd1);
        chk("lit_lw_alusrc",    0, 32'(ex_alusrc[0]),     32'd1);
        chk("lit_lw_alu",       0, 32'(ex_alucontrol[0]), 32'b0010);
        idle(2);
        chk("lit_lw_wb_rw",     0, 32'(wb_regwrite[0]),   32'd1);
        chk("lit_lw_wb_res",    0, 32'(wb_resultsrc[0]),  32'b01);
        idle(1);
        chk("lit_lw_retired",   0, 32'(retired[0]),       32'd1);

        // R-type sub held two cycles by stall
        step(0, 1, 6'b000000, 6'b100010, 1, 0);
        chk("lit_stall1_ex_valid", 0, 32'(ex_valid[0]), 32'd0);
        step(0, 1, 6'b000000, 6'b100010, 1, 0);
        chk("lit_stall2_ex_valid", 0, 32'(ex_valid[0]), 32'd0);
        step(0, 1, 6'b000000, 6'b100010, 0, 0);
        chk("lit_sub_alu",    0, 32'(ex_alucontrol[0]), 32'b0110);
        chk("lit_sub_regdst", 0, 32'(ex_regdst[0]),     32'b01);
        idle(3);
        chk("lit_sub_retired", 0, 32'(retired[0]), 32'd2);

        // ori legal only with the extended ISA
        step(1, 0, 6'd0, 6'd0, 0, 0);
        drive(0, 1, 6'b001101, 6'd0, 0, 0);
        chk("lit_ori_illegal_base", 1, 32'(id_illegal[1]), 32'd1);
        chk("lit_ori_illegal_ext",  0, 32'(id_illegal[0]), 32'd0);
        tick();
        chk("lit_ori_exc",    1, 32'(exc_illegal[1]), 32'd1);
        chk("lit_ori_exc_op", 1, 32'(exc_op[1]),      32'b001101);
        idle(3);
        chk("lit_ori_no_wb", 1, 32'(wb_valid[1]), 32'd0);

        drive(0, 1, 6'b000011, 6'd0, 0, 0);
        chk("lit_jal_jump", 0, 32'(id_jump[0]), 32'd1);
        tick();
        chk("lit_jal_regdst", 0, 32'(ex_regdst[0]), 32'b10);
        idle(2);
        chk("lit_jal_wb_rw",  0, 32'(wb_regwrite[0]),  32'd1);
        chk("lit_jal_wb_res", 0, 32'(wb_resultsrc[0]), 32'b10);
        chk("lit_jal_keep_exc_op", 1, 32'(exc_op[1]), 32'b001101);

        // first illegal wins exc_op; flushed illegal is not trapped
        step(1, 0, 6'd0, 6'd0, 0, 0);
        step(0, 1, 6'b000000, 6'b111111, 0, 0);
        step(0, 1, 6'b111111, 6'd0, 0, 0);
        chk("lit_two_illegal_exc",    0, 32'(exc_illegal[0]), 32'd1);
        chk("lit_two_illegal_exc_op", 0, 32'(exc_op[0]),      32'd0);
        step(1, 0, 6'd0, 6'd0, 0, 0);
        step(0, 1, 6'b111111, 6'd0, 0, 1);
        chk("lit_flush_no_exc", 0, 32'(exc_illegal[0]), 32'd0);
        step(0, 1, 6'b100011, 6'd0, 1, 1);
        chk("lit_stall_flush_bubble", 0, 32'(ex_valid[0]), 32'd0);

        // 4-bit retire counter wrap
        step(1, 0, 6'd0, 6'd0, 0, 0);
        for (int k = 0; k < 17; k++) step(0, 1, 6'b001000, 6'd0, 0, 0);
        idle(2);
        chk("lit_wrap_zero", 0, 32'(retired[0]), 32'd0);
        idle(1);
        chk("lit_wrap_one",  0, 32'(retired[0]), 32'd1);

        // reset with sw in MEM and beq in EX
        step(0, 1, 6'b111111, 6'd0, 0, 0);
        step(0, 1, 6'b101011, 6'd0, 0, 0);
        drive(0, 1, 6'b000100, 6'd0, 0, 0);
        chk("lit_beq_branch", 0, 32'(id_branch[0]), 32'd1);
        tick();
        chk("lit_pre_rst_memwrite", 0, 32'(mem_memwrite[0]), 32'd1);
        step(1, 0, 6'd0, 6'd0, 0, 0);
        chk("lit_rst_ex_valid",  0, 32'(ex_valid[0]),     32'd0);
        chk("lit_rst_mem_valid", 0, 32'(mem_valid[0]),    32'd0);
        chk("lit_rst_memwrite",  0, 32'(mem_memwrite[0]), 32'd0);
        chk("lit_rst_exc",       0, 32'(exc_illegal[0]),  32'd0);
        chk("lit_rst_exc_op",    0, 32'(exc_op[0]),       32'd0);
        chk("lit_rst_retired",   0, 32'(retired[0]),      32'd0);

        for (int k = 0; k < 500; k++) begin
            bit [5:0] op, fn;
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
            fn = ($urandom_range(0, 15) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, op, fn,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
Next-generation control unit for the pipelined MIPS core. It decodes op/funct in ID and drives early branch/jump controls combinationally. It carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages, with bubble insertion on stall or flush. It also traps illegal encodings into a sticky exception record and counts retired instructions. The extended ISA (ori, andi, slti, lui, bne, jal) is enabled by parameter.

Parameters:
EXT_ISA, 1, 1 = decode ori/andi/slti/lui/bne/jal; 0 = those opcodes are illegal
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_op  in  6  opcode [31:26]
id_funct  in  6  funct [5:0]
stall  in  1  hazard unit holds ID; a bubble goes into EX
flush_ex  in  1  squash the ID instruction (taken branch/jump); a bubble goes into EX
id_branch  out  1  beq (combinational)
id_bne  out  1  bne (combinational)
id_jump  out  1  j/jal (combinational)
id_illegal  out  1  id_valid and encoding illegal (combinational)
ex_valid  out  1  EX holds a real instruction
ex_alusrc  out  1  1 = immediate operand
ex_zeroext  out  1  1 = zero-extend immediate (ori/andi)
ex_regdst  out  2  00 rt, 01 rd, 10 r31
ex_alucontrol  out  4  ALU operation
mem_valid  out  1  MEM holds a real instruction
mem_memwrite  out  1  store
wb_valid  out  1  WB holds a real instruction
wb_regwrite  out  1  register-file write enable
wb_resultsrc  out  2  00 ALU, 01 memory, 10 PC+4
exc_illegal  out  1  sticky illegal-instruction flag
exc_op  out  6  opcode of first illegal instruction
retired  out  CNT_W  count of instructions leaving WB

Behaviour:
- Decode (combinational). Opcodes and their bundles:
  - R-type 000000: regwrite, regdst=01.
  - lw 100011: regwrite, alusrc, resultsrc=01, add.
  - sw 101011: memwrite, alusrc, add.
  - beq 000100: branch, sub.
  - addi 001000: regwrite, alusrc, add.
  - j 000010: jump.
  - EXT_ISA only:
    - ori 001101: regwrite, alusrc, zeroext, or.
    - andi 001100: regwrite, alusrc, zeroext, and.
    - slti 001010: regwrite, alusrc, slt.
    - lui 001111: regwrite, alusrc, lui.
    - bne 000101: bne, sub.
    - jal 000011: jump, regwrite, regdst=10, resultsrc=10.
- R-type funct mapping to alucontrol: add 100000→0010, sub 100010→0110, and 100100→0000, or 100101→0001, slt 101010→0111.
- alucontrol encodings for immediates: add 0010, sub 0110, and 0000, or 0001, slt 0111, lui 1000 (imm<<16).
- Illegal: any other opcode, or R-type with any other funct. An illegal instruction decodes to an all-zero bundle with valid=0. id_branch/id_bne/id_jump are all 0 when id_valid=0 or illegal.
- Stage registers advance every cycle; there is no back-pressure beyond the stall rule.
- ID/EX loads the decoded bundle with valid = id_valid & !illegal & !stall & !flush_ex. Otherwise it loads a bubble (all fields 0).
- EX/MEM and MEM/WB copy the previous stage unconditionally. Bubbles propagate with all write enables 0.
- Latency: a legal instruction accepted in cycle N shows ex_* in N+1, mem_* in N+2, wb_* in N+3.
- stall and flush_ex both high gives a single bubble.
- Exceptions: exc_illegal is set when id_illegal & !stall & !flush_ex.
  - exc_op captures id_op only on the first set; later illegal instructions leave it unchanged.
  - The flag is cleared only by reset.
- retired increments by 1 each cycle wb_valid=1. It wraps modulo 2^CNT_W with no saturation.
- Reset (any cycle, including mid-pipeline): every registered output goes to 0 on the next edge, including all valid bits, exc_illegal, exc_op and retired. In-flight instructions are discarded.

Decomposition:
- Package ctrl_pkg holds:
  - opcode and funct localparams;
  - ALUCTL_* encodings;
  - REGDST_* and RES_* encodings;
  - packed struct ctrl_t {valid, regwrite, regdst, alusrc, zeroext, alucontrol, memwrite, resultsrc, branch, bne, jump};
  - constant CTRL_BUBBLE.
- Sub-module ctrl_decode (combinational op/funct → ctrl_t + illegal, parameter EXT_ISA). ctrl_pipeline instantiates it and owns all registers.

Test Plan:
- Reset, then lw (op 100011) with id_valid=1 at cycle 0 → ex_valid=1, alusrc=1, alucontrol=0010 at cycle 1; wb_regwrite=1, wb_resultsrc=01 at cycle 3; retired=1 at cycle 4.
- R-type sub (funct 100010) with stall=1 for 2 cycles, then stall=0 → 2 bubbles (ex_valid=0), then ex_alucontrol=0110, ex_regdst=01. retired counts only the one instruction.
- EXT_ISA=1 with jal (000011) → id_jump=1; wb_regwrite=1, ex_regdst=10, wb_resultsrc=10. With EXT_ISA=0, ori (001101) → id_illegal=1, exc_illegal=1, exc_op=001101, and no writes reach WB.
- Two illegal instructions (funct 111111, then op 111111) → exc_op stays 000000 from the first. An illegal op under flush_ex=1 does not set the flag.
- CNT_W=4, 17 back-to-back addi → retired wraps to 0 after 16, reads 1 after 17.
- Reset asserted while sw is in MEM and beq is in EX → next cycle all valid bits, mem_memwrite, exc_* and retired are 0.
